// File: rtl/multicycle_controller_pkg.sv
// Shared opcode, state and control-encoding definitions for the multi-cycle controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package controller_pkg;

    // RV32I opcodes the controller sequences
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

    // MemtoReg write-back source select
    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    // ALUOp class handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_PASSB = 2'b11;

    // Jump target select
    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JAL  = 2'b01;
    localparam logic [1:0] JMP_JALR = 2'b10;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_LUI, OP_JAL, OP_JALR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Fetch handshake, memory completion and datapath control strobes of the controller.
// Latency: n/a (wires only).
// Backpressure: instr_ready deasserts while an instruction is in flight.
// Ports: master = controller side (drives strobes), slave = fetch unit / datapath / memory side.
// Optional: CTRL_PERF_CNT_EN adds retired_cnt and stall_cnt.
interface multicycle_controller_if #(
    parameter int OPCODE_W = 7
);
    logic [OPCODE_W-1:0] Opcode;
    logic                instr_valid;
    logic                instr_ready;
    logic                mem_ready;
    logic                IRWrite;
    logic                ALUSrc;
    logic [1:0]          MemtoReg;
    logic                RegWrite;
    logic                MemRead;
    logic                MemWrite;
    logic [1:0]          ALUOp;
    logic                Branch;
    logic [1:0]          Jump;
    logic                PCWrite;
    logic                illegal;
    logic                mem_err;
    logic                busy;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0]         retired_cnt;
    logic [31:0]         stall_cnt;
`endif

    modport master (
`ifdef CTRL_PERF_CNT_EN
        output retired_cnt, stall_cnt,
`endif
        input  Opcode, instr_valid, mem_ready,
        output instr_ready, IRWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
               ALUOp, Branch, Jump, PCWrite, illegal, mem_err, busy
    );

    modport slave (
`ifdef CTRL_PERF_CNT_EN
        input  retired_cnt, stall_cnt,
`endif
        output Opcode, instr_valid, mem_ready,
        input  instr_ready, IRWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
               ALUOp, Branch, Jump, PCWrite, illegal, mem_err, busy
    );

endinterface

// File: rtl/multicycle_controller_timeout.sv
// Counts consecutive MEM cycles without mem_ready and flags the last allowed one.
// Latency: expired_o is combinational on enable_i in the MEM_TIMEOUT_CYC-th stalled cycle.
// Backpressure: none; clear_i has priority over enable_i.
// Ports: clk/reset, enable_i (stalled MEM cycle), clear_i (not in MEM or completed), expired_o.
module mem_timeout_counter #(
    parameter int MEM_TIMEOUT_CYC = 16,
    parameter int TMO_W           = $clog2(MEM_TIMEOUT_CYC + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_i,
    input  logic clear_i,
    output logic expired_o
);
    localparam logic [TMO_W-1:0] LAST = TMO_W'(MEM_TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    // The current stalled cycle is the one that brings the count to MEM_TIMEOUT_CYC
    assign expired_o = enable_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || expired_o) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequences RV32I instructions through FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes.
// Latency: BR 3, ALU/LUI/JAL/JALR 4, SW 3+N, LW 4+N cycles accept-to-PCWrite (N = MEM cycles).
// Backpressure: instr_ready only in FETCH; MEM holds until mem_ready or timeout.
// Ports: clk, reset (async active-high), bus (multicycle_controller_if.master).
// Optional: CTRL_PERF_CNT_EN adds retired/stall counters on the bus.
module multicycle_controller
    import controller_pkg::*;
#(
    parameter int OPCODE_W        = 7,
    parameter int MEM_TIMEOUT_CYC = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    localparam int TMO_W = (MEM_TIMEOUT_CYC > 0) ? $clog2(MEM_TIMEOUT_CYC + 1) : 1;

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic                tmo_expired;
    logic                is_lw;

    assign is_lw = (opcode_q == OP_LW);

    generate
        if (MEM_TIMEOUT_CYC > 0) begin : g_tmo
            mem_timeout_counter #(
                .MEM_TIMEOUT_CYC (MEM_TIMEOUT_CYC),
                .TMO_W           (TMO_W)
            ) u_tmo (
                .clk       (clk),
                .reset     (reset),
                .enable_i  ((state_q == MEM) && !bus.mem_ready),
                .clear_i   ((state_q != MEM) || bus.mem_ready),
                .expired_o (tmo_expired)
            );
        end else begin : g_no_tmo
            assign tmo_expired = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d         = state_q;
        opcode_d        = opcode_q;
        bus.instr_ready = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.ALUSrc      = 1'b0;
        bus.MemtoReg    = MTR_ALU;
        bus.RegWrite    = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.ALUOp       = ALUOP_ADD;
        bus.Branch      = 1'b0;
        bus.Jump        = JMP_NONE;
        bus.PCWrite     = 1'b0;
        bus.illegal     = 1'b0;
        bus.mem_err     = 1'b0;
        bus.busy        = (state_q != FETCH);

        case (state_q)
            FETCH: begin
                // reset gating keeps the handshake quiet while reset is held
                bus.instr_ready = !reset;
                if (bus.instr_valid && !reset) begin
                    bus.IRWrite = 1'b1;
                    opcode_d    = bus.Opcode;
                    state_d     = DECODE;
                end
            end
            DECODE: begin
                if (is_legal(opcode_q)) begin
                    state_d = EXEC;
                end else begin
                    // retire-by-skip so the fetch unit moves past the bad word
                    bus.illegal = 1'b1;
                    bus.PCWrite = 1'b1;
                    state_d     = FETCH;
                end
            end
            EXEC: begin
                state_d = WB;
                case (opcode_q)
                    OP_R:    bus.ALUOp = ALUOP_FUNCT;
                    OP_I:    begin bus.ALUOp = ALUOP_FUNCT; bus.ALUSrc = 1'b1; end
                    OP_LW,
                    OP_SW:   begin bus.ALUSrc = 1'b1; state_d = MEM; end
                    OP_JALR: bus.ALUSrc = 1'b1;
                    OP_LUI:  bus.ALUOp = ALUOP_PASSB;
                    OP_BR: begin
                        bus.ALUOp   = ALUOP_BR;
                        bus.Branch  = 1'b1;
                        bus.PCWrite = 1'b1;
                        state_d     = FETCH;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                bus.MemRead  = is_lw;
                bus.MemWrite = !is_lw;
                // completion outranks a timeout landing in the same cycle
                if (bus.mem_ready) begin
                    if (is_lw) begin
                        state_d = WB;
                    end else begin
                        bus.PCWrite = 1'b1;
                        state_d     = FETCH;
                    end
                end else if (tmo_expired) begin
                    bus.mem_err = 1'b1;
                    state_d     = FETCH;
                end
            end
            WB: begin
                bus.RegWrite = 1'b1;
                bus.PCWrite  = 1'b1;
                state_d      = FETCH;
                case (opcode_q)
                    OP_LW:   bus.MemtoReg = MTR_MEM;
                    OP_JAL:  begin bus.MemtoReg = MTR_PC4; bus.Jump = JMP_JAL;  end
                    OP_JALR: begin bus.MemtoReg = MTR_PC4; bus.Jump = JMP_JALR; end
                    default: ;
                endcase
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] retired_q, stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (bus.PCWrite && !bus.illegal && !bus.mem_err) begin
                retired_q <= retired_q + 32'd1;
            end
            if (((state_q == MEM) && !bus.mem_ready) || ((state_q == FETCH) && !bus.instr_valid)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign bus.retired_cnt = retired_q;
    assign bus.stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller against a per-instruction trace model.
// Latency: n/a.
// Backpressure: n/a.
module tb_multicycle_controller;
    localparam int TMO = 16;

    localparam logic [6:0] B_R    = 7'b0110011;
    localparam logic [6:0] B_I    = 7'b0010011;
    localparam logic [6:0] B_LW   = 7'b0000011;
    localparam logic [6:0] B_SW   = 7'b0100011;
    localparam logic [6:0] B_BR   = 7'b1100011;
    localparam logic [6:0] B_LUI  = 7'b0110111;
    localparam logic [6:0] B_JAL  = 7'b1101111;
    localparam logic [6:0] B_JALR = 7'b1100111;

    logic clk;
    logic reset;

    multicycle_controller_if #(.OPCODE_W(7)) bus ();

    multicycle_controller #(
        .OPCODE_W        (7),
        .MEM_TIMEOUT_CYC (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       instr_ready;
        logic       IRWrite;
        logic       ALUSrc;
        logic [1:0] MemtoReg;
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic [1:0] ALUOp;
        logic       Branch;
        logic [1:0] Jump;
        logic       PCWrite;
        logic       illegal;
        logic       mem_err;
        logic       busy;
    } outs_t;

    outs_t exp_q[$];
    outs_t obs[$];
    int    checks = 0;
    int    errors = 0;
    int    m_retired = 0;
    int    m_stall = 0;
    int    n_rd, n_wr, n_rw, n_pcw, n_err, n_ill, first_pcw;
    logic [6:0] ops [8] = '{B_R, B_I, B_LW, B_SW, B_BR, B_LUI, B_JAL, B_JALR};

    function automatic outs_t sample();
        outs_t o;
        o.instr_ready = bus.instr_ready;
        o.IRWrite     = bus.IRWrite;
        o.ALUSrc      = bus.ALUSrc;
        o.MemtoReg    = bus.MemtoReg;
        o.RegWrite    = bus.RegWrite;
        o.MemRead     = bus.MemRead;
        o.MemWrite    = bus.MemWrite;
        o.ALUOp       = bus.ALUOp;
        o.Branch      = bus.Branch;
        o.Jump        = bus.Jump;
        o.PCWrite     = bus.PCWrite;
        o.illegal     = bus.illegal;
        o.mem_err     = bus.mem_err;
        o.busy        = bus.busy;
        return o;
    endfunction

    function automatic bit legal(input logic [6:0] op);
        for (int i = 0; i < 8; i++) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // One cycle of stimulus plus the outputs the spec requires in that cycle
    task automatic drive(input logic v, input logic [6:0] op, input logic mr, input outs_t e);
        @(negedge clk);
        bus.instr_valid = v;
        bus.Opcode      = op;
        bus.mem_ready   = mr;
        exp_q.push_back(e);
    endtask

    task automatic drive_idle();
        outs_t e;
        e = '0;
        e.instr_ready = 1'b1;
        m_stall++;
        drive(1'b0, 7'($urandom), rb(), e);
    endtask

    // k = MEM cycle in which mem_ready rises (0 or >TMO: never)
    task automatic run_instr(input logic [6:0] op, input int idle, input int k, input bit hold);
        outs_t e;
        for (int i = 0; i < idle; i++) drive_idle();
        e = '0;
        e.instr_ready = 1'b1;
        e.IRWrite     = 1'b1;
        drive(1'b1, op, rb(), e);
        e = '0;
        e.busy = 1'b1;
        if (!legal(op)) begin
            e.illegal = 1'b1;
            e.PCWrite = 1'b1;
            drive(hold | rb(), 7'($urandom), rb(), e);
            return;
        end
        drive(hold | rb(), 7'($urandom), rb(), e);
        e = '0;
        e.busy   = 1'b1;
        e.ALUSrc = (op == B_I) || (op == B_LW) || (op == B_SW) || (op == B_JALR);
        e.ALUOp  = (op == B_R || op == B_I) ? 2'd2 : (op == B_BR) ? 2'd1 : (op == B_LUI) ? 2'd3 : 2'd0;
        if (op == B_BR) begin
            e.Branch  = 1'b1;
            e.PCWrite = 1'b1;
            drive(hold | rb(), 7'($urandom), rb(), e);
            m_retired++;
            return;
        end
        drive(hold | rb(), 7'($urandom), rb(), e);
        if (op == B_LW || op == B_SW) begin
            for (int m = 1; m <= TMO; m++) begin
                e = '0;
                e.busy     = 1'b1;
                e.MemRead  = (op == B_LW);
                e.MemWrite = (op == B_SW);
                if (m == k) begin
                    if (op == B_SW) begin
                        e.PCWrite = 1'b1;
                        drive(hold | rb(), 7'($urandom), 1'b1, e);
                        m_retired++;
                        return;
                    end
                    drive(hold | rb(), 7'($urandom), 1'b1, e);
                    break;
                end
                m_stall++;
                if (m == TMO) begin
                    e.mem_err = 1'b1;
                    drive(hold | rb(), 7'($urandom), 1'b0, e);
                    return;
                end
                drive(hold | rb(), 7'($urandom), 1'b0, e);
            end
        end
        e = '0;
        e.busy     = 1'b1;
        e.RegWrite = 1'b1;
        e.PCWrite  = 1'b1;
        e.MemtoReg = (op == B_LW) ? 2'd1 : (op == B_JAL || op == B_JALR) ? 2'd2 : 2'd0;
        e.Jump     = (op == B_JAL) ? 2'd1 : (op == B_JALR) ? 2'd2 : 2'd0;
        drive(hold | rb(), 7'($urandom), rb(), e);
        m_retired++;
    endtask

    task automatic tally();
        n_rd = 0; n_wr = 0; n_rw = 0; n_pcw = 0; n_err = 0; n_ill = 0; first_pcw = -1;
        for (int i = 0; i < obs.size(); i++) begin
            n_rd  += int'(obs[i].MemRead);
            n_wr  += int'(obs[i].MemWrite);
            n_rw  += int'(obs[i].RegWrite);
            n_pcw += int'(obs[i].PCWrite);
            n_err += int'(obs[i].mem_err);
            n_ill += int'(obs[i].illegal);
            if (obs[i].PCWrite && first_pcw < 0) first_pcw = i;
        end
    endtask

    task automatic directed(input logic [6:0] op, input int k, input bit hold);
        obs.delete();
        run_instr(op, 0, k, hold);
        #3;
        tally();
    endtask

    // Compare process: every driven cycle is checked against the model trace
    initial begin
        outs_t a, e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = sample();
                obs.push_back(a);
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_trace: got %h want %h (t=%0t)", a, e, $time);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        outs_t e;
        logic [6:0] op;
        reset           = 1'b1;
        bus.instr_valid = 1'b0;
        bus.Opcode      = '0;
        bus.mem_ready   = 1'b0;
        #3;
        check("reset_outs_zero", 32'(sample()), 32'd0);
        check("reset_instr_ready", 32'(bus.instr_ready), 32'd0);
        repeat (2) @(negedge clk);
        #3 reset = 1'b0;

        // Reset while an LW sits in MEM with MemRead high
        e = '0; e.instr_ready = 1'b1; e.IRWrite = 1'b1;
        drive(1'b1, B_LW, 1'b0, e);
        e = '0; e.busy = 1'b1;
        drive(1'b0, 7'h00, 1'b0, e);
        e.ALUSrc = 1'b1;
        drive(1'b0, 7'h00, 1'b0, e);
        e = '0; e.busy = 1'b1; e.MemRead = 1'b1;
        drive(1'b0, 7'h00, 1'b0, e);
        drive(1'b0, 7'h00, 1'b0, e);
        #3;
        check("memread_before_reset", 32'(bus.MemRead), 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_outs_zero", 32'(sample()), 32'd0);
        @(negedge clk);
        #3 reset = 1'b0;
        m_stall   = 1;
        m_retired = 0;
        obs.delete();
        repeat (3) drive_idle();
        #3;
        tally();
        check("post_reset_no_regwrite", n_rw, 0);
        check("post_reset_instr_ready", 32'(obs[0].instr_ready), 32'd1);

        // ADD with instr_valid held high
        directed(B_R, 0, 1);
        check("add_irwrite_c0", 32'(obs[0].IRWrite), 32'd1);
        check("add_aluop_exec", 32'(obs[2].ALUOp), 32'd2);
        check("add_pcwrite_cycle", first_pcw, 3);
        check("add_regwrite_c3", 32'(obs[3].RegWrite), 32'd1);
        check("add_memtoreg", 32'(obs[3].MemtoReg), 32'd0);

        // LW completing in the third MEM cycle
        directed(B_LW, 3, 0);
        check("lw_memread_cycles", n_rd, 3);
        check("lw_pcwrite_cycle", first_pcw, 6);
        check("lw_memtoreg", 32'(obs[6].MemtoReg), 32'd1);
        check("lw_regwrite", 32'(obs[6].RegWrite), 32'd1);

        // SW never acknowledged: timeout
        directed(B_SW, 0, 0);
        check("sw_tmo_memwrite_cycles", n_wr, 16);
        check("sw_tmo_mem_err_count", n_err, 1);
        check("sw_tmo_mem_err_cycle", 32'(obs[18].mem_err), 32'd1);
        check("sw_tmo_no_pcwrite", n_pcw, 0);
        @(posedge clk);
        #1;
        check("sw_tmo_back_in_fetch", 32'(bus.busy), 32'd0);

        // mem_ready in the timeout cycle wins
        directed(B_LW, TMO, 0);
        check("lw_edge_no_mem_err", n_err, 0);
        check("lw_edge_memread_cycles", n_rd, 16);
        check("lw_edge_pcwrite_cycle", first_pcw, 19);
        check("lw_edge_regwrite", n_rw, 1);

        // Illegal opcode, then the next fetch slot
        obs.delete();
        run_instr(7'b1111111, 0, 0, 0);
        drive_idle();
        #3;
        tally();
        check("ill_pulse_decode", 32'(obs[1].illegal), 32'd1);
        check("ill_pcwrite_decode", 32'(obs[1].PCWrite), 32'd1);
        check("ill_pulse_count", n_ill, 1);
        check("ill_no_writes", n_rw + n_wr, 0);
        check("ill_ready_next", 32'(obs[2].instr_ready), 32'd1);

        // JAL then BEQ, then JALR
        directed(B_JAL, 0, 0);
        check("jal_jump", 32'(obs[3].Jump), 32'd1);
        check("jal_memtoreg", 32'(obs[3].MemtoReg), 32'd2);
        check("jal_regwrite", 32'(obs[3].RegWrite), 32'd1);
        directed(B_BR, 0, 0);
        check("beq_branch", 32'(obs[2].Branch), 32'd1);
        check("beq_aluop", 32'(obs[2].ALUOp), 32'd1);
        check("beq_pcwrite_cycle", first_pcw, 2);
        check("beq_no_regwrite", n_rw, 0);
        directed(B_JALR, 0, 0);
        check("jalr_jump", 32'(obs[3].Jump), 32'd2);
        check("jalr_alusrc", 32'(obs[2].ALUSrc), 32'd1);

        // Randomized instruction stream
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 8) == 8) begin
                do op = 7'($urandom); while (legal(op));
            end else begin
                op = ops[$urandom_range(0, 7)];
            end
            run_instr(op, $urandom_range(0, 3), $urandom_range(1, 20), 1'($urandom_range(0, 1)));
        end
        drive_idle();
        @(posedge clk);
        #1;
`ifdef CTRL_PERF_CNT_EN
        check("retired_cnt", bus.retired_cnt, 32'(m_retired));
        check("stall_cnt", bus.stall_cnt, 32'(m_stall));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
